isa_multiciclo: RTL and testbench
=================================

Name: isa_multiciclo

Overview:
- Parametrised multi-cycle successor of the single-cycle ISA datapath: register file, ALU and data RAM.
- Sequenced by an FSM with valid/ready handshakes on both the instruction input and the result output.
- Adds a destination-register writeback field, a wider ALU op set, and a zero flag.
- Executes one instruction at a time; sits between an instruction sequencer/testbench and downstream result consumers.

Parameters:
DW, 32, data width of registers, ALU and RAM words
NREG, 32, number of registers (power of two, >=2)
DEPTH, 32, data RAM words (power of two, >=2)
(derived localparams) AW=$clog2(NREG), MW=$clog2(DEPTH), IW=3*AW+MW+5 (default 25)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction offered
in_ready  out  1  block can accept an instruction (IDLE only)
instr  in  IW  fields MSB->LSB: rd[AW], rs1[AW], rs2[AW], br_we[1], alu_op[3], ram_dir[MW], ram_we[1]
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
salida  out  DW  RAM word read at ram_dir
zero  out  1  ALU result of the instruction was 0
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, any state): FSM->IDLE; in_ready=1, out_valid=0, salida=0, zero=0, busy=0; all registers cleared to 0; in-flight instruction discarded. RAM contents are not reset.
- FSM states: IDLE -> READ -> EXEC -> MEM -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch instr and go to READ. No accept in any other state.
- READ: latch op1=R[rs1], op2=R[rs2].
- EXEC: latch res=ALU(op1,op2,alu_op); zero<=(res==0).
- ALU ops, modulo 2^DW:
  - 000 add, 001 sub, 010 and, 011 or, 100 xor
  - 101 slt: signed compare, result 1 or 0
  - 110 sll by op2[$clog2(DW)-1:0]
  - 111 srl (logical), same shift amount
- MEM, same edge:
  - if br_we, R[rd]<=res
  - if ram_we, RAM[ram_dir]<=res
  - salida<=RAM[ram_dir], write-first: new value when ram_we=1
  - go to DONE
- DONE: out_valid=1; salida and zero held stable until out_ready. On out_valid&&out_ready go to IDLE and out_valid<=0.
- Latency: accept edge at cycle 0 -> out_valid high from cycle 4. Minimum initiation interval is 5 cycles with out_ready tied high.
- Hazards: none. The next instruction's READ always observes the previous writeback.
- rs1==rs2, and rd==rs1 in the same instruction: reads use pre-write values.
- Backpressure: out_ready=0 holds DONE indefinitely; in_ready stays 0.
- in_valid in a non-IDLE state is ignored; no buffering.

Optional Feature:
- Macro ZERO_REG_EN.
  - Defined: R[0] reads as 0 always and writes to rd=0 are discarded.
  - Undefined: R[0] is an ordinary register.

Decomposition:
- Package isa_pkg holds:
  - ALU op encodings (ALU_ADD..ALU_SRL, 3-bit)
  - FSM state enum (S_IDLE, S_READ, S_EXEC, S_MEM, S_DONE)
  - field-offset helper constants
- Natural sub-module: alu_param, combinational, DW-parameterised: op1, op2, alu_op -> res.
- Register file and RAM stay inline arrays in the top.

Test Plan:
- Reset then instr rd=1, rs1=0, rs2=0, br_we=1, op=add, ram_we=0 -> out_valid at cycle 4, salida=RAM[dir] (pre-initialised), zero=1, R1=0.
- Backdoor R2=5, R3=7; sub rd=4, rs1=2, rs2=3, ram_we=1, dir=6 -> salida=32'hFFFFFFFE, zero=0, RAM[6]=32'hFFFFFFFE, R4=32'hFFFFFFFE.
- slt with R2=-1, R3=1 -> 1. sll R3 by R2[4:0]=31 -> 32'h80000000. srl 32'h80000000 by 31 -> 1.
- out_ready=0 for 10 cycles in DONE -> salida stable, in_ready=0, second in_valid ignored. Then out_ready=1 -> IDLE next cycle.
- Assert rst_n low during EXEC -> outputs zeroed immediately, no RAM/BR write; next instruction executes normally.
- ZERO_REG_EN defined: write 9 to rd=0, then add rs1=0 -> res 0. Undefined: same sequence -> res 9.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared definitions for the multi-cycle ISA datapath: ALU opcodes, FSM states
// and instruction field offsets (offsets depend on the RAM address width).
package isa_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_MEM  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Instruction layout, LSB first: ram_we, ram_dir[mw], alu_op[3], br_we, rs2, rs1, rd
    localparam int OFF_RAM_WE  = 0;
    localparam int OFF_RAM_DIR = 1;

    function automatic int off_alu_op(input int mw);
        return mw + 1;
    endfunction

    function automatic int off_br_we(input int mw);
        return mw + 4;
    endfunction

    function automatic int off_rs2(input int mw);
        return mw + 5;
    endfunction

    function automatic int off_rs1(input int aw, input int mw);
        return aw + mw + 5;
    endfunction

    function automatic int off_rd(input int aw, input int mw);
        return 2 * aw + mw + 5;
    endfunction

endpackage

// File: rtl/alu_param.sv
// Combinational DW-wide ALU used in the EXEC step of isa_multiciclo.
module alu_param
    import isa_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] op1,
    input  logic [DW-1:0] op2,
    input  logic [2:0]    alu_op,
    output logic [DW-1:0] res
);

    localparam int SW = $clog2(DW);

    logic [SW-1:0] w_shamt;
    logic          w_lt;

    assign w_shamt = op2[SW-1:0];
    assign w_lt    = ($signed(op1) < $signed(op2));

    // Operation select
    always_comb begin
        res = {DW{1'b0}};
        case (alu_op)
            ALU_ADD: res = op1 + op2;
            ALU_SUB: res = op1 - op2;
            ALU_AND: res = op1 & op2;
            ALU_OR:  res = op1 | op2;
            ALU_XOR: res = op1 ^ op2;
            ALU_SLT: res = {{(DW-1){1'b0}}, w_lt};
            ALU_SLL: res = op1 << w_shamt;
            ALU_SRL: res = op1 >> w_shamt;
            default: res = {DW{1'b0}};
        endcase
    end

endmodule

// File: rtl/isa_multiciclo.sv
// Multi-cycle ISA datapath: register file, ALU and data RAM sequenced IDLE->READ->EXEC->MEM->DONE.
// Build option: define ZERO_REG_EN to hardwire R[0] to zero.
module isa_multiciclo
    import isa_pkg::*;
#(
    parameter int DW    = 32,
    parameter int NREG  = 32,
    parameter int DEPTH = 32
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    input  logic [3*$clog2(NREG)+$clog2(DEPTH)+5-1:0]     instr,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [DW-1:0]                                  salida,
    output logic                                           zero,
    output logic                                           busy
);

    localparam int AW      = $clog2(NREG);
    localparam int MW      = $clog2(DEPTH);
    localparam int IW      = 3 * AW + MW + 5;
    localparam int OFF_OP  = off_alu_op(MW);
    localparam int OFF_BWE = off_br_we(MW);
    localparam int OFF_RS2 = off_rs2(MW);
    localparam int OFF_RS1 = off_rs1(AW, MW);
    localparam int OFF_RD  = off_rd(AW, MW);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_instr;
    logic [DW-1:0]   r_regs [NREG];
    logic [DW-1:0]   r_ram  [DEPTH];
    logic [DW-1:0]   r_op1;
    logic [DW-1:0]   r_op2;
    logic [DW-1:0]   r_res;
    logic [DW-1:0]   r_salida;
    logic            r_zero;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_busy;

    logic [AW-1:0]   w_rd;
    logic [AW-1:0]   w_rs1;
    logic [AW-1:0]   w_rs2;
    logic            w_br_we;
    logic [2:0]      w_alu_op;
    logic [MW-1:0]   w_dir;
    logic            w_ram_we;
    logic [DW-1:0]   w_src1;
    logic [DW-1:0]   w_src2;
    logic [DW-1:0]   w_alu_res;
    logic            w_rf_we;
    logic            w_accept;

    assign w_rd     = r_instr[OFF_RD  +: AW];
    assign w_rs1    = r_instr[OFF_RS1 +: AW];
    assign w_rs2    = r_instr[OFF_RS2 +: AW];
    assign w_br_we  = r_instr[OFF_BWE];
    assign w_alu_op = r_instr[OFF_OP +: 3];
    assign w_dir    = r_instr[OFF_RAM_DIR +: MW];
    assign w_ram_we = r_instr[OFF_RAM_WE];
    assign w_accept = in_valid && r_in_ready;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign salida    = r_salida;
    assign zero      = r_zero;
    assign busy      = r_busy;

    // Register-file read ports and writeback enable
    always_comb begin
        w_src1  = r_regs[w_rs1];
        w_src2  = r_regs[w_rs2];
        w_rf_we = w_br_we;
`ifdef ZERO_REG_EN
        if (w_rs1 == {AW{1'b0}}) w_src1 = {DW{1'b0}};
        else                     w_src1 = r_regs[w_rs1];
        if (w_rs2 == {AW{1'b0}}) w_src2 = {DW{1'b0}};
        else                     w_src2 = r_regs[w_rs2];
        if (w_rd == {AW{1'b0}})  w_rf_we = 1'b0;
        else                     w_rf_we = w_br_we;
`endif
    end

    alu_param #(.DW(DW)) u_alu (
        .op1    (r_op1),
        .op2    (r_op2),
        .alu_op (w_alu_op),
        .res    (w_alu_res)
    );

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_READ;
                else          w_state_nxt = S_IDLE;
            end
            S_READ: w_state_nxt = S_EXEC;
            S_EXEC: w_state_nxt = S_MEM;
            S_MEM:  w_state_nxt = S_DONE;
            S_DONE: begin
                if (out_ready) w_state_nxt = S_IDLE;
                else           w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register with status outputs registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    // Datapath: instruction latch, operand fetch, execute, writeback and RAM read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr  <= {IW{1'b0}};
            r_op1    <= {DW{1'b0}};
            r_op2    <= {DW{1'b0}};
            r_res    <= {DW{1'b0}};
            r_salida <= {DW{1'b0}};
            r_zero   <= 1'b0;
            for (int i = 0; i < NREG; i++) r_regs[i] <= {DW{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) r_instr <= instr;
                S_READ: begin
                    r_op1 <= w_src1;
                    r_op2 <= w_src2;
                end
                S_EXEC: begin
                    r_res  <= w_alu_res;
                    r_zero <= (w_alu_res == {DW{1'b0}});
                end
                S_MEM: begin
                    if (w_rf_we) r_regs[w_rd] <= r_res;
                    r_salida <= w_ram_we ? r_res : r_ram[w_dir];
                end
                default: r_instr <= r_instr;
            endcase
        end
    end

    // Data RAM write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if ((r_state == S_MEM) && w_ram_we) r_ram[w_dir] <= r_res;
    end

endmodule

// File: tb/tb_isa_multiciclo.sv
// Self-checking bench for isa_multiciclo: directed cases plus randomized instructions
// checked against an instruction-level reference model.
module tb_isa_multiciclo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [24:0] instr = 25'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] salida;
    logic        zero;
    logic        busy;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_ram  [32];

    isa_multiciclo dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .salida    (salida),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] read_reg(input int idx);
`ifdef ZERO_REG_EN
        if (idx == 0) return 32'd0;
`endif
        return m_regs[idx];
    endfunction

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input int op);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6: return a << b[4:0];
            default: return a >> b[4:0];
        endcase
    endfunction

    task automatic set_reg(input int idx, input logic [31:0] val);
        dut.r_regs[idx] = val;
        m_regs[idx] = val;
    endtask

    task automatic set_ram(input int idx, input logic [31:0] val);
        dut.r_ram[idx] = val;
        m_ram[idx] = val;
    endtask

    function automatic logic [24:0] enc(input int rd, input int rs1, input int rs2, input int bwe,
                                        input int op, input int dir, input int rwe);
        logic [4:0] f_rd, f_rs1, f_rs2, f_dir;
        logic [2:0] f_op;
        f_rd = rd[4:0]; f_rs1 = rs1[4:0]; f_rs2 = rs2[4:0]; f_dir = dir[4:0]; f_op = op[2:0];
        return {f_rd, f_rs1, f_rs2, bwe[0], f_op, f_dir, rwe[0]};
    endfunction

    // One instruction from IDLE back to IDLE; out_ready held low for 'stall' DONE cycles.
    task automatic run_instr(input int rd, input int rs1, input int rs2, input int bwe,
                             input int op, input int dir, input int rwe, input int stall,
                             output logic [31:0] got_salida, output logic got_zero);
        logic [31:0] res, exp_salida;
        int cyc;
        res = alu_ref(read_reg(rs1), read_reg(rs2), op);
        exp_salida = (rwe != 0) ? res : m_ram[dir];
        if (bwe != 0) begin
`ifdef ZERO_REG_EN
            if (rd != 0) m_regs[rd] = res;
`else
            m_regs[rd] = res;
`endif
        end
        if (rwe != 0) m_ram[dir] = res;

        @(negedge clk);
        out_ready = (stall == 0);
        in_valid = 1'b1;
        instr = enc(rd, rs1, rs2, bwe, op, dir, rwe);
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            in_valid = 1'b0;
        end while (!out_valid && cyc < 20);
        check_eq("latency", 64'(cyc), 64'd4);
        check_eq("salida", 64'(salida), 64'(exp_salida));
        check_eq("zero", 64'(zero), 64'(res == 32'd0));
        got_salida = salida;
        got_zero = zero;
        for (int k = 0; k < stall; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("hold_salida", 64'(salida), 64'(exp_salida));
            check_eq("hold_valid", 64'(out_valid), 64'd1);
            check_eq("hold_in_ready", 64'(in_ready), 64'd0);
            if (k == 2) begin
                in_valid = 1'b1;
                instr = enc(1, 2, 3, 1, 0, 4, 1);
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("back_idle", 64'({in_ready, out_valid, busy}), 64'b100);
    endtask

    logic [31:0] s;
    logic        z;

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;

        repeat (3) @(negedge clk);
        check_eq("rst_outputs", 64'({in_ready, out_valid, zero, busy}), 64'b1000);
        check_eq("rst_salida", 64'(salida), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 32; i++) set_ram(i, 32'hA5A5_0000 | 32'(i));

        // add R1 = R0 + R0, read preset RAM word
        run_instr(1, 0, 0, 1, 0, 3, 0, 0, s, z);
        check_eq("add0_salida", 64'(s), 64'h0000_0000_A5A5_0003);
        check_eq("add0_zero", 64'(z), 64'd1);

        set_reg(2, 32'd5);
        set_reg(3, 32'd7);
        run_instr(4, 2, 3, 1, 1, 6, 1, 0, s, z);
        check_eq("sub_salida", 64'(s), 64'h0000_0000_FFFF_FFFE);
        check_eq("sub_zero", 64'(z), 64'd0);
        run_instr(5, 4, 0, 0, 3, 9, 0, 0, s, z);
        run_instr(5, 0, 0, 0, 0, 6, 0, 0, s, z);
        check_eq("ram6", 64'(s), 64'h0000_0000_FFFF_FFFE);

        set_reg(2, 32'hFFFF_FFFF);
        set_reg(3, 32'd1);
        run_instr(7, 2, 3, 1, 5, 8, 1, 0, s, z);
        check_eq("slt", 64'(s), 64'd1);
        run_instr(8, 3, 2, 1, 6, 9, 1, 0, s, z);
        check_eq("sll", 64'(s), 64'h0000_0000_8000_0000);
        run_instr(9, 8, 2, 1, 7, 10, 1, 0, s, z);
        check_eq("srl", 64'(s), 64'd1);

        // Backpressure with an ignored offer during DONE; the follow-up reads show no effect
        run_instr(12, 9, 8, 1, 4, 11, 1, 10, s, z);
        run_instr(13, 1, 12, 0, 3, 4, 0, 0, s, z);

        // Reset during EXEC: no RAM or register write lands
        @(negedge clk);
        in_valid = 1'b1;
        instr = enc(14, 2, 3, 1, 0, 20, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_flags", 64'({in_ready, out_valid, zero, busy}), 64'b1000);
        check_eq("mid_rst_salida", 64'(salida), 64'd0);
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        run_instr(1, 0, 0, 0, 0, 20, 0, 0, s, z);
        check_eq("no_ram_write", 64'(s), 64'h0000_0000_A5A5_0014);
        run_instr(2, 14, 2, 0, 3, 21, 0, 0, s, z);
        check_eq("regs_cleared", 64'(z), 64'd1);

        // Writes to R0 then read R0
        set_reg(10, 32'd9);
        run_instr(0, 10, 0, 1, 0, 0, 0, 0, s, z);
        run_instr(11, 0, 12, 0, 0, 13, 1, 0, s, z);
`ifdef ZERO_REG_EN
        check_eq("zero_reg", 64'(s), 64'd0);
`else
        check_eq("zero_reg", 64'(s), 64'd9);
`endif

        // Randomized instructions against the reference model
        for (int i = 1; i < 32; i++) set_reg(i, $urandom);
        for (int t = 0; t < 60; t++) begin
            run_instr(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                      int'($urandom_range(0, 31)), int'($urandom_range(0, 1)),
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
                      int'($urandom_range(0, 1)), int'($urandom_range(0, 4)), s, z);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
